// File: rtl/dso_pkg.sv
// Shared DSO_dig definitions: assembler states, command width
// and the opcode map decoded by the dispatcher.
package dso_pkg;

   typedef enum logic [1:0] {IDLE, B1, B2, HOLD} asm_state_t;

   localparam int CMD_W = 24;

   localparam logic [7:0] DUMP_CH  = 8'h01;
   localparam logic [7:0] CFG_GAIN = 8'h02;
   localparam logic [7:0] TRIG_POS = 8'h03;
   localparam logic [7:0] TRIG_LVL = 8'h04;
   localparam logic [7:0] TRIG_CFG = 8'h05;
   localparam logic [7:0] EEP_WR   = 8'h08;
   localparam logic [7:0] EEP_RD   = 8'h09;

endpackage

// File: rtl/cmd_assembler_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at
// all-ones instead of wrapping.
module sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (inc && !(&cnt))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/cmd_assembler.sv
// Gathers three UART RX bytes into a 24-bit command, holds it
// for the dispatcher, drops stalled frames and counts overruns.
module cmd_assembler
   import dso_pkg::*;
#(
   parameter int TO_CYC = 104166,
   parameter int TO_W   = 17,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_rdy,
   input  logic [7:0]       rx_data,
   output logic             clr_rx_rdy,
   output logic [CMD_W-1:0] cmd,
   output logic             cmd_rdy,
   input  logic             clr_cmd_rdy,
   output logic             frame_err,
   output logic [ERR_W-1:0] ovr_cnt,
   output logic [ERR_W-1:0] to_cnt
);

   asm_state_t       state, nxt;
   logic [CMD_W-1:0] cmd_nxt;
   logic             cmd_rdy_nxt;
   logic [TO_W-1:0]  tmr;
   logic             acc, tmo, ovr, tmr_end;

   // rx_rdy is still high while our clear is in flight
   assign acc     = rx_rdy & ~clr_rx_rdy;
   assign tmr_end = (tmr == TO_W'(TO_CYC - 1));

   always_comb begin
      nxt         = state;
      cmd_nxt     = cmd;
      cmd_rdy_nxt = cmd_rdy;
      tmo         = 1'b0;
      ovr         = 1'b0;
      unique case (state)
         IDLE: begin
            if (acc) begin
               nxt            = B1;
               cmd_nxt[23:16] = rx_data;
            end
         end
         B1: begin
            if (acc) begin
               nxt           = B2;
               cmd_nxt[15:8] = rx_data;
            end else if (tmr_end) begin
               nxt = IDLE;
               tmo = 1'b1;
            end
         end
         B2: begin
            if (acc) begin
               nxt          = HOLD;
               cmd_nxt[7:0] = rx_data;
               cmd_rdy_nxt  = 1'b1;
            end else if (tmr_end) begin
               nxt = IDLE;
               tmo = 1'b1;
            end
         end
         HOLD: begin
            if (clr_cmd_rdy) begin
               cmd_rdy_nxt = 1'b0;
               nxt         = IDLE;
               if (acc) begin
                  nxt            = B1;
                  cmd_nxt[23:16] = rx_data;
               end
            end else if (acc) begin
               ovr = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cmd        <= '0;
         cmd_rdy    <= 1'b0;
         clr_rx_rdy <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= nxt;
         cmd        <= cmd_nxt;
         cmd_rdy    <= cmd_rdy_nxt;
         clr_rx_rdy <= acc;
         frame_err  <= tmo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         tmr <= '0;
      else if ((state == B1 || state == B2) && !acc && !tmo)
         tmr <= tmr + 1'b1;
      else
         tmr <= '0;
   end

   sat_cnt #(.W(ERR_W)) u_ovr (
      .clk (clk),
      .clr (rst),
      .inc (ovr),
      .cnt (ovr_cnt)
   );

   sat_cnt #(.W(ERR_W)) u_to (
      .clk (clk),
      .clr (rst),
      .inc (tmo),
      .cnt (to_cnt)
   );

endmodule
